alu_operand_seq: RTL and testbench
==================================

ALU_OPERAND_SEQ -- requirements
Module: alu_operand_seq

Interface
REQ-001 The parameter list SHALL be: DB_CNT, default 20'd500000, number of consecutive cycles a synchronized button level must differ from its debounced level before the debounced level flips (legal range 2..2^20-1).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset, named clk and rst_n.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 btn_a  input  1  raw push button "load operand A"; asynchronous, bouncing.
REQ-006 btn_b  input  1  raw push button "load operand B"; asynchronous, bouncing.
REQ-007 btn_f  input  1  raw push button "execute / latch flags"; asynchronous, bouncing.
REQ-008 SW  input  32  switch bank; operand value, with SW[3:0] as ALU opcode.
REQ-009 a_q  output  32  registered operand A to the ALU.
REQ-010 b_q  output  32  registered operand B to the ALU.
REQ-011 op_q  output  4  registered opcode to the ALU.
REQ-012 exec  output  1  one-cycle strobe; downstream latches result and flags on it.
REQ-013 err  output  1  one-cycle strobe for an out-of-sequence press.
REQ-014 state  output  2  current sequencer state code.
REQ-015 exec_cnt  output  8  count of exec strobes issued.

Function
REQ-016 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-017 Each button SHALL have a 20-bit debounce counter: increments each cycle the synchronized level differs from the debounced level, clears to 0 on any cycle they match; on reaching DB_CNT the debounced level flips and the counter clears.
REQ-018 A press SHALL be a registered one-cycle pulse on the rising edge of the debounced level; release generates nothing.
REQ-019 With a button held high from the first sampling edge E0, the resulting register update, state change, exec or err SHALL be visible exactly after edge E0+DB_CNT+3.
REQ-020 States SHALL be IDLE=2'b00, HAVE_A=2'b01, HAVE_B=2'b10, DONE=2'b11.
REQ-021 press_a in any state SHALL load a_q<=SW and go to HAVE_A.
REQ-022 press_b in HAVE_A, HAVE_B or DONE SHALL load b_q<=SW and go to HAVE_B; in IDLE it SHALL assert err and change nothing else.
REQ-023 press_f in HAVE_B or DONE SHALL load op_q<=SW[3:0], assert exec for one cycle, increment exec_cnt, and go to DONE; in IDLE or HAVE_A it SHALL assert err only.
REQ-024 Simultaneous presses in one cycle SHALL be resolved with priority A > B > F; only the winner acts; losers are discarded silently (no err).
REQ-025 exec_cnt SHALL wrap 8'hFF -> 8'h00.
REQ-026 exec and err SHALL never be high in the same cycle and SHALL each be high for exactly one cycle per triggering press.
REQ-027 Registers not named by the acting press SHALL hold their values.

Reset
REQ-028 On rst_n low, asynchronously: a_q, b_q = 32'h0; op_q = 4'h0; exec, err = 0; state = IDLE; exec_cnt = 8'h00; synchronizers, debounced levels, counters and press pulses = 0.
REQ-029 Reset asserted mid-debounce or mid-sequence SHALL discard the pending press; a button still held at reset release SHALL require a full DB_CNT qualification before producing a press.

Verification (DB_CNT=4)
REQ-030 Reset release, btn_a high 10 cycles, SW=32'h12345678 -> after edge E0+7: a_q=32'h12345678, state=01, exec=0, err=0.
REQ-031 btn_b pulsed high 3 cycles then low (bounce) -> no press; b_q, state, err unchanged.
REQ-032 Full sequence A(SW=5), B(SW=3), F(SW=32'h0) -> a_q=5, b_q=3, op_q=0, one exec pulse, exec_cnt=1, state=11.
REQ-033 From IDLE press F -> single err pulse, exec=0, state=00; from DONE press F with SW[3:0]=4'h1 -> exec pulse, op_q=1, exec_cnt increments.
REQ-034 btn_a and btn_b rising in the same cycle from HAVE_B -> a_q loads, b_q holds, state=01, err=0.
REQ-035 256 execute presses from DONE -> exec_cnt returns to 8'h00; rst_n low mid-debounce -> all outputs at reset values, no late press.

Source files
------------

// File: rtl/alu_operand_seq.sv
// Operand sequencer for a push-button ALU front panel: debounces three buttons
// and steps A -> B -> execute, loading operands/opcode from the switch bank.
module alu_operand_seq #(
    parameter logic [19:0] DB_CNT = 20'd500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_f,
    input  logic [31:0] SW,
    output logic [31:0] a_q,
    output logic [31:0] b_q,
    output logic [3:0]  op_q,
    output logic        exec,
    output logic        err,
    output logic [1:0]  state,
    output logic [7:0]  exec_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        HAVE_A = 2'b01,
        HAVE_B = 2'b10,
        DONE   = 2'b11
    } state_t;

    localparam int NBTN = 3;

    logic [NBTN-1:0] btn_raw;
    logic [NBTN-1:0] sync_p0;
    logic [NBTN-1:0] sync_p1;
    logic [NBTN-1:0] db_lvl;
    logic [NBTN-1:0] db_lvl_p2;
    logic [NBTN-1:0] press_p3;
    logic [19:0]     db_cnt [NBTN];

    state_t state_r;
    state_t state_nxt;
    logic   ld_a;
    logic   ld_b;
    logic   ld_f;
    logic   err_nxt;

    assign btn_raw = {btn_f, btn_b, btn_a};
    assign state   = state_r;

    // Stage p0/p1: synchronizer; p2: debounce; p3: rising-edge press pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0   <= '0;
            sync_p1   <= '0;
            db_lvl    <= '0;
            db_lvl_p2 <= '0;
            press_p3  <= '0;
            for (int i = 0; i < NBTN; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync_p0   <= btn_raw;
            sync_p1   <= sync_p0;
            db_lvl_p2 <= db_lvl;
            press_p3  <= db_lvl & ~db_lvl_p2;
            for (int i = 0; i < NBTN; i++) begin
                if (sync_p1[i] == db_lvl[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_CNT - 20'd1) begin
                    db_cnt[i] <= '0;
                    db_lvl[i] <= ~db_lvl[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + 20'd1;
                end
            end
        end
    end

    // Fixed priority A > B > F; a losing press is dropped without raising err
    always_comb begin
        state_nxt = state_r;
        ld_a      = 1'b0;
        ld_b      = 1'b0;
        ld_f      = 1'b0;
        err_nxt   = 1'b0;
        if (press_p3[0]) begin
            ld_a      = 1'b1;
            state_nxt = HAVE_A;
        end else if (press_p3[1]) begin
            if (state_r == IDLE) begin
                err_nxt = 1'b1;
            end else begin
                ld_b      = 1'b1;
                state_nxt = HAVE_B;
            end
        end else if (press_p3[2]) begin
            if (state_r == HAVE_B || state_r == DONE) begin
                ld_f      = 1'b1;
                state_nxt = DONE;
            end else begin
                err_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Stage p4: operand/opcode registers and strobes toward the ALU
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            exec     <= 1'b0;
            err      <= 1'b0;
            exec_cnt <= '0;
        end else begin
            exec <= ld_f;
            err  <= err_nxt;
            if (ld_a) begin
                a_q <= SW;
            end
            if (ld_b) begin
                b_q <= SW;
            end
            if (ld_f) begin
                op_q     <= SW[3:0];
                exec_cnt <= exec_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq with a short debounce count.
module tb_alu_operand_seq;

    localparam logic [19:0] DBC = 20'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        btn_a = 1'b0;
    logic        btn_b = 1'b0;
    logic        btn_f = 1'b0;
    logic [31:0] SW = '0;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  op_q;
    logic        exec;
    logic        err;
    logic [1:0]  state;
    logic [7:0]  exec_cnt;

    alu_operand_seq #(.DB_CNT(DBC)) dut (
        .clk(clk), .rst_n(rst_n), .btn_a(btn_a), .btn_b(btn_b), .btn_f(btn_f),
        .SW(SW), .a_q(a_q), .b_q(b_q), .op_q(op_q), .exec(exec), .err(err),
        .state(state), .exec_cnt(exec_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int exec_seen = 0;
    int err_seen = 0;
    int both_hi = 0;

    always @(negedge clk) begin
        if (exec) exec_seen++;
        if (err) err_seen++;
        if (exec && err) both_hi++;
    end

    typedef struct {
        logic        rst;
        logic [2:0]  btns;   // {f, b, a}
        logic [31:0] sw;
        int          hold;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [3:0]  eop;
        logic [1:0]  est;
        logic [7:0]  ecnt;
        int          eexec;
        int          eerr;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic apply(input logic [2:0] btns, input logic [31:0] sw, input int hold);
        @(negedge clk);
        SW = sw;
        {btn_f, btn_b, btn_a} = btns;
        repeat (hold) @(negedge clk);
        {btn_f, btn_b, btn_a} = 3'b000;
        repeat (14) @(negedge clk);
    endtask

    task automatic chk_all(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                           input logic [3:0] eop, input logic [1:0] est, input logic [7:0] ecnt);
        chk({tag, ".a_q"}, a_q, ea);
        chk({tag, ".b_q"}, b_q, eb);
        chk({tag, ".op_q"}, {28'h0, op_q}, {28'h0, eop});
        chk({tag, ".state"}, {30'h0, state}, {30'h0, est});
        chk({tag, ".exec_cnt"}, {24'h0, exec_cnt}, {24'h0, ecnt});
    endtask

    initial begin
        int x0;
        int e0;
        vecs[0]  = '{1'b0, 3'b010, 32'hDEAD0000, 3,  32'h12345678, 32'h0, 4'h0, 2'b01, 8'd0, 0, 0};
        vecs[1]  = '{1'b0, 3'b001, 32'h5,        10, 32'h5,  32'h0,  4'h0, 2'b01, 8'd0, 0, 0};
        vecs[2]  = '{1'b0, 3'b010, 32'h3,        10, 32'h5,  32'h3,  4'h0, 2'b10, 8'd0, 0, 0};
        vecs[3]  = '{1'b0, 3'b100, 32'h0,        10, 32'h5,  32'h3,  4'h0, 2'b11, 8'd1, 1, 0};
        vecs[4]  = '{1'b0, 3'b100, 32'hABCD0001, 10, 32'h5,  32'h3,  4'h1, 2'b11, 8'd2, 1, 0};
        vecs[5]  = '{1'b0, 3'b010, 32'h7,        10, 32'h5,  32'h7,  4'h1, 2'b10, 8'd2, 0, 0};
        vecs[6]  = '{1'b0, 3'b011, 32'h9,        10, 32'h9,  32'h7,  4'h1, 2'b01, 8'd2, 0, 0};
        vecs[7]  = '{1'b0, 3'b100, 32'h2,        10, 32'h9,  32'h7,  4'h1, 2'b01, 8'd2, 0, 1};
        vecs[8]  = '{1'b0, 3'b110, 32'h8,        10, 32'h9,  32'h8,  4'h1, 2'b10, 8'd2, 0, 0};
        vecs[9]  = '{1'b0, 3'b111, 32'h10,       10, 32'h10, 32'h8,  4'h1, 2'b01, 8'd2, 0, 0};
        vecs[10] = '{1'b0, 3'b010, 32'h11,       10, 32'h10, 32'h11, 4'h1, 2'b10, 8'd2, 0, 0};
        vecs[11] = '{1'b0, 3'b100, 32'hFFFFFFFE, 10, 32'h10, 32'h11, 4'hE, 2'b11, 8'd3, 1, 0};
        vecs[12] = '{1'b1, 3'b100, 32'h5,        10, 32'h0,  32'h0,  4'h0, 2'b00, 8'd0, 0, 1};
        vecs[13] = '{1'b0, 3'b010, 32'h6,        10, 32'h0,  32'h0,  4'h0, 2'b00, 8'd0, 0, 1};
        vecs[14] = '{1'b0, 3'b001, 32'hFFFFFFFF, 10, 32'hFFFFFFFF, 32'h0, 4'h0, 2'b01, 8'd0, 0, 0};
        vecs[15] = '{1'b0, 3'b100, 32'h3,        10, 32'hFFFFFFFF, 32'h0, 4'h0, 2'b01, 8'd0, 0, 1};

        // Reset values while rst_n is low
        repeat (2) @(negedge clk);
        chk_all("reset", 32'h0, 32'h0, 4'h0, 2'b00, 8'h00);
        chk("reset.exec", {31'h0, exec}, 32'h0);
        chk("reset.err", {31'h0, err}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Exact latency: action visible after E0+DB_CNT+3
        SW = 32'h12345678;
        btn_a = 1'b1;
        @(posedge clk);                        // E0
        repeat (DBC + 2) @(posedge clk);       // E0+6
        #1;
        chk("lat.early_state", {30'h0, state}, 32'h0);
        chk("lat.early_a", a_q, 32'h0);
        @(posedge clk);                        // E0+7
        #1;
        chk("lat.a_q", a_q, 32'h12345678);
        chk("lat.state", {30'h0, state}, 32'h1);
        chk("lat.exec", {31'h0, exec}, 32'h0);
        chk("lat.err", {31'h0, err}, 32'h0);
        repeat (4) @(negedge clk);
        btn_a = 1'b0;
        repeat (14) @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rst) do_reset();
            x0 = exec_seen;
            e0 = err_seen;
            apply(vecs[i].btns, vecs[i].sw, vecs[i].hold);
            chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb, vecs[i].eop,
                    vecs[i].est, vecs[i].ecnt);
            chk($sformatf("vec%0d.exec_pulses", i), exec_seen - x0, vecs[i].eexec);
            chk($sformatf("vec%0d.err_pulses", i), err_seen - e0, vecs[i].eerr);
        end

        // exec_cnt wrap over 256 executes from a fresh start
        do_reset();
        apply(3'b001, 32'h1, 10);
        apply(3'b010, 32'h2, 10);
        x0 = exec_seen;
        e0 = err_seen;
        for (int i = 0; i < 256; i++) begin
            apply(3'b100, i, 10);
            if (i == 254) chk("wrap.cnt_ff", {24'h0, exec_cnt}, 32'hFF);
        end
        chk("wrap.cnt_00", {24'h0, exec_cnt}, 32'h0);
        chk("wrap.exec_pulses", exec_seen - x0, 256);
        chk("wrap.err_pulses", err_seen - e0, 0);
        chk("wrap.state", {30'h0, state}, 32'h3);
        chk("wrap.op_q", {28'h0, op_q}, 32'hF);

        // Reset mid-debounce with button released during reset: no late press
        @(negedge clk);
        SW = 32'hCAFEF00D;
        btn_a = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk_all("midrst", 32'h0, 32'h0, 4'h0, 2'b00, 8'h00);
        btn_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        e0 = err_seen;
        repeat (20) @(negedge clk);
        chk("midrst.late_a", a_q, 32'h0);
        chk("midrst.late_state", {30'h0, state}, 32'h0);
        chk("midrst.late_err", err_seen - e0, 0);

        // Button still held at reset release needs a full qualification
        @(negedge clk);
        btn_a = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);                        // first sampling edge after release
        repeat (DBC + 2) @(posedge clk);
        #1;
        chk("held.early_a", a_q, 32'h0);
        @(posedge clk);
        #1;
        chk("held.a_q", a_q, 32'hCAFEF00D);
        chk("held.state", {30'h0, state}, 32'h1);
        repeat (4) @(negedge clk);
        btn_a = 1'b0;
        repeat (14) @(negedge clk);

        chk("exec_err_exclusive", both_hi, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
